// File: rtl/bus_arbiter_ctrl.sv
// Round-robin bus arbiter with a registered one-hot grant and a one-cycle dead gap between owners.
// Defining ARB_TIMEOUT_EN adds a hold-timeout watchdog that force-releases and masks the owner.
module bus_arbiter_ctrl #(
    parameter int unsigned INT_MASTER_COUNT = 2,
    parameter int unsigned INT_SLAVE_COUNT  = 3,
    parameter int unsigned SLAVE_ID_WIDTH   = 2,
    parameter int unsigned HOLD_TIMEOUT     = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [INT_MASTER_COUNT-1:0]                req,
    input  logic [INT_MASTER_COUNT*SLAVE_ID_WIDTH-1:0] req_slave,
    input  logic [INT_MASTER_COUNT-1:0]                done,
    output logic [INT_MASTER_COUNT-1:0]                grant,
    output logic [SLAVE_ID_WIDTH-1:0]                  grant_slave,
    output logic                                       bus_busy,
    output logic                                       timeout,
    output logic [$clog2(INT_MASTER_COUNT)-1:0]        last_owner
);

    localparam int unsigned OwnerWidth = $clog2(INT_MASTER_COUNT);
    localparam logic [SLAVE_ID_WIDTH-1:0] MaxSlaveId = SLAVE_ID_WIDTH'(INT_SLAVE_COUNT);
    localparam logic [OwnerWidth-1:0] LastMaster = OwnerWidth'(INT_MASTER_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e                      state_q, state_d;
    logic [INT_MASTER_COUNT-1:0] grant_q, grant_d;
    logic [SLAVE_ID_WIDTH-1:0]   slave_q, slave_d;
    logic [OwnerWidth-1:0]       owner_q, owner_d;
    logic                        busy_q, busy_d;
    logic                        timeout_q, timeout_d;

    logic [SLAVE_ID_WIDTH-1:0]   slave_id [INT_MASTER_COUNT];
    logic [INT_MASTER_COUNT-1:0] eligible;
    logic [INT_MASTER_COUNT-1:0] mask_q;
    logic                        any_eligible;
    logic [OwnerWidth-1:0]       winner;
    logic                        normal_release;
    logic                        forced_release;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(HOLD_TIMEOUT) + 1;
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(HOLD_TIMEOUT - 1);

    logic [CntWidth-1:0]         cnt_q, cnt_d;
    logic [INT_MASTER_COUNT-1:0] mask_d;

    assign forced_release = (state_q == StHold) && (cnt_q == CntLimit);

    always_comb begin
        // A timed-out master stays masked until it is seen with req low.
        mask_d = mask_q & req;
        cnt_d  = '0;
        if (state_q == StHold) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
        if (forced_release && !normal_release) begin
            mask_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end
`else
    assign mask_q         = '0;
    assign forced_release = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < INT_MASTER_COUNT; i++) begin
            slave_id[i] = req_slave[i*SLAVE_ID_WIDTH +: SLAVE_ID_WIDTH];
            eligible[i] = req[i] && (slave_id[i] != '0) && (slave_id[i] <= MaxSlaveId)
                          && !mask_q[i];
        end
    end

    // Scan farthest-first so the index closest after the last owner overwrites the rest.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        winner       = owner_q;
        any_eligible = 1'b0;
        for (int k = INT_MASTER_COUNT; k >= 1; k--) begin
            idx = (32'(owner_q) + 32'(k)) % INT_MASTER_COUNT;
            if (eligible[idx]) begin
                winner       = OwnerWidth'(idx);
                any_eligible = 1'b1;
            end
        end
    end

    assign normal_release = done[owner_q] || !req[owner_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        slave_d   = slave_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_eligible) begin
                    state_d         = StHold;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    slave_d         = slave_id[winner];
                    owner_d         = winner;
                end
            end
            StHold: begin
                if (normal_release || forced_release) begin
                    state_d   = StGap;
                    grant_d   = '0;
                    slave_d   = '0;
                    timeout_d = forced_release && !normal_release;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            slave_q   <= '0;
            owner_q   <= LastMaster;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            slave_q   <= slave_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_slave = slave_q;
    assign bus_busy    = busy_q;
    assign timeout     = timeout_q;
    assign last_owner  = owner_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Self-checking bench for bus_arbiter_ctrl: directed scenarios plus random traffic vs a reference model.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog (HOLD_TIMEOUT is then 8).
module tb_bus_arbiter_ctrl;

    localparam int N  = 2;
    localparam int W  = 2;
    localparam int S  = 3;
    localparam int OW = $clog2(N);
`ifdef ARB_TIMEOUT_EN
    localparam int HT = 8;
    localparam bit TimeoutEn = 1'b1;
`else
    localparam int HT = 1024;
    localparam bit TimeoutEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_slave = '0;
    logic [N-1:0]   done = '0;
    logic [N-1:0]   grant;
    logic [W-1:0]   grant_slave;
    logic           bus_busy;
    logic           timeout;
    logic [OW-1:0]  last_owner;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = none), dead-gap flag, hold length, last winner, masks.
    int m_owner = -1;
    int m_slave = 0;
    int m_last  = N - 1;
    int m_cnt   = 0;
    bit m_gap   = 1'b0;
    bit m_timeout = 1'b0;
    bit m_mask [N];

    bus_arbiter_ctrl #(
        .INT_MASTER_COUNT (N),
        .INT_SLAVE_COUNT  (S),
        .SLAVE_ID_WIDTH   (W),
        .HOLD_TIMEOUT     (HT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_slave   (req_slave),
        .done        (done),
        .grant       (grant),
        .grant_slave (grant_slave),
        .bus_busy    (bus_busy),
        .timeout     (timeout),
        .last_owner  (last_owner)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit nm [N];
        bit by_master;
        bit by_watchdog;
        int i;
        int sl;
        if (rst) begin
            m_owner = -1; m_slave = 0; m_last = N - 1; m_cnt = 0; m_gap = 0; m_timeout = 0;
            for (int j = 0; j < N; j++) m_mask[j] = 1'b0;
            return;
        end
        nm = m_mask;
        for (int j = 0; j < N; j++) if (!req[j]) nm[j] = 1'b0;
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            by_master   = done[m_owner] || !req[m_owner];
            by_watchdog = TimeoutEn && (m_cnt >= HT - 1);
            if (by_master || by_watchdog) begin
                if (!by_master) begin
                    m_timeout = 1'b1;
                    nm[m_owner] = 1'b1;
                end
                m_owner = -1; m_slave = 0; m_gap = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                i  = (m_last + k) % N;
                sl = int'(req_slave[i*W +: W]);
                if (m_owner < 0 && req[i] && sl >= 1 && sl <= S && !m_mask[i]) begin
                    m_owner = i; m_last = i; m_slave = sl; m_cnt = 0;
                end
            end
        end
        m_mask = nm;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slave(input int i, input int v);
        req_slave[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = '0; req_slave = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; done = '0; req_slave = '1;
        tick();
        tick();
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL reset_grant got=%b want=00", grant); end
        checks++; if (grant_slave !== 2'd0) begin errors++;
            $display("FAIL reset_slave got=%0d want=0", grant_slave); end
        checks++; if (bus_busy !== 1'b0 || timeout !== 1'b0) begin errors++;
            $display("FAIL reset_flags got busy=%b timeout=%b want 0 0", bus_busy, timeout); end
        checks++; if (last_owner !== 1'b1) begin errors++;
            $display("FAIL reset_last_owner got=%0d want=1", last_owner); end
        rst = 1'b0; req = '0; req_slave = '0;
        tick();
    endtask

    task automatic test_single_master();
        do_reset();
        req = 2'b01; set_slave(0, 2);
        tick();
        checks++; if (grant !== 2'b01 || grant_slave !== 2'd2 || bus_busy !== 1'b1) begin errors++;
            $display("FAIL single_grant got=%b/%0d/%b want=01/2/1", grant, grant_slave, bus_busy);
        end
        tick();
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL single_hold got=%b want=01", grant); end
        done = 2'b01;
        tick();
        done = '0;
        checks++; if (grant !== 2'b00 || bus_busy !== 1'b0 || grant_slave !== 2'd0) begin errors++;
            $display("FAIL single_release got=%b/%0d/%b want=00/0/0", grant, grant_slave, bus_busy);
        end
        tick();
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL single_gap got=%b want=00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL single_regrant got=%b want=01", grant); end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 2'b11; set_slave(0, 1); set_slave(1, 3);
        tick();
        checks++; if (grant !== 2'b01 || grant_slave !== 2'd1) begin errors++;
            $display("FAIL rr_first got=%b/%0d want=01/1", grant, grant_slave); end
        done = 2'b01;
        tick();
        done = '0;
        tick();
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL rr_gap got=%b want=00", grant); end
        tick();
        checks++; if (grant !== 2'b10 || grant_slave !== 2'd3 || last_owner !== 1'b1) begin
            errors++;
            $display("FAIL rr_second got=%b/%0d/%0d want=10/3/1", grant, grant_slave, last_owner);
        end
        done = 2'b10;
        tick();
        done = '0;
        tick();
        tick();
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL rr_third got=%b want=01", grant); end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_invalid_slave();
        do_reset();
        req = 2'b01; set_slave(0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (grant !== 2'b00) begin errors++;
                $display("FAIL invalid_ignored cyc=%0d got=%b want=00", c, grant); end
        end
        set_slave(0, 1);
        tick();
        checks++; if (grant !== 2'b01 || grant_slave !== 2'd1) begin errors++;
            $display("FAIL invalid_fixed got=%b/%0d want=01/1", grant, grant_slave); end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_hold_stable();
        do_reset();
        req = 2'b01; set_slave(0, 1);
        tick();
        set_slave(0, 2);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (grant !== 2'b01 || grant_slave !== 2'd1) begin errors++;
                $display("FAIL hold_stable cyc=%0d got=%b/%0d want=01/1", c, grant, grant_slave);
            end
        end
        req = '0;
        tick();
        checks++; if (grant !== 2'b00 || grant_slave !== 2'd0) begin errors++;
            $display("FAIL hold_req_drop got=%b/%0d want=00/0", grant, grant_slave); end
        repeat (2) tick();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        req = 2'b01; set_slave(0, 1); set_slave(1, 2);
        tick();
        checks++; if (last_owner !== 1'b0 || grant !== 2'b01) begin errors++;
            $display("FAIL rsthold_pre got=%b/%0d want=01/0", grant, last_owner); end
        rst = 1'b1;
        tick();
        checks++; if (grant !== 2'b00 || last_owner !== 1'b1 || bus_busy !== 1'b0) begin errors++;
            $display("FAIL rsthold_drop got=%b/%0d/%b want=00/1/0", grant, last_owner, bus_busy);
        end
        rst = 1'b0; req = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL rsthold_first got=%b want=01", grant); end
        req = '0;
        repeat (3) tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 2'b01; set_slave(0, 1); set_slave(1, 2);
        tick();
        for (int c = 0; c < HT - 1; c++) begin
            tick();
            checks++; if (grant !== 2'b01 || timeout !== 1'b0) begin errors++;
                $display("FAIL to_holding cyc=%0d got=%b/%b want=01/0", c, grant, timeout); end
        end
        tick();
        checks++; if (grant !== 2'b00 || timeout !== 1'b1) begin errors++;
            $display("FAIL to_fire got=%b/%b want=00/1", grant, timeout); end
        req = 2'b11;
        tick();
        checks++; if (timeout !== 1'b0) begin errors++;
            $display("FAIL to_pulse got=%b want=0", timeout); end
        tick();
        checks++; if (grant !== 2'b10) begin errors++;
            $display("FAIL to_other got=%b want=10", grant); end
        req = 2'b01;
        tick();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (grant !== 2'b00) begin errors++;
                $display("FAIL to_masked cyc=%0d got=%b want=00", c, grant); end
        end
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL to_unmask got=%b want=01", grant); end
        req = '0;
        repeat (3) tick();
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]  exp_grant;
        logic [W-1:0]  exp_slave;
        logic [OW-1:0] exp_last;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 9) == 0) set_slave(i, int'($urandom_range(0, 3)));
                done[i] = ($urandom_range(0, 4) == 0);
            end
            tick();
            exp_grant = '0;
            if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
            exp_slave = W'(m_slave);
            exp_last  = OW'(m_last);
            checks++; if (grant !== exp_grant) begin errors++;
                $display("FAIL rand_grant cyc=%0d got=%b want=%b", c, grant, exp_grant); end
            checks++; if (grant_slave !== exp_slave) begin errors++;
                $display("FAIL rand_slave cyc=%0d got=%0d want=%0d", c, grant_slave, exp_slave); end
            checks++; if (bus_busy !== (m_owner >= 0)) begin errors++;
                $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, bus_busy, m_owner >= 0); end
            checks++; if (timeout !== m_timeout) begin errors++;
                $display("FAIL rand_timeout cyc=%0d got=%b want=%b", c, timeout, m_timeout); end
            checks++; if (last_owner !== exp_last) begin errors++;
                $display("FAIL rand_last cyc=%0d got=%0d want=%0d", c, last_owner, exp_last); end
        end
        rst = 1'b0; done = '0; req = '0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_round_robin();
        test_invalid_slave();
        test_hold_stable();
        test_reset_in_hold();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/bus_arbiter_ctrl.md
Name: bus_arbiter_ctrl

Overview:
- Arbitrates the shared internal serial bus between INT_MASTER_COUNT masters. Each master requests ownership for a transaction with one of the slaves.
- Sits between the master request lines and the bus interconnect mux. Produces a registered one-hot grant and the selected slave ID that steers the interconnect.
- Uses round-robin fairness, a mandatory one-cycle dead cycle between owners, and an optional hold-timeout watchdog.

Parameters:
- INT_MASTER_COUNT, 2, number of requesting masters (2..8).
- INT_SLAVE_COUNT, 3, number of slaves; slave IDs run 1..INT_SLAVE_COUNT; ID 0 means no_slave.
- SLAVE_ID_WIDTH, 2, width of one slave ID; must satisfy 2**SLAVE_ID_WIDTH > INT_SLAVE_COUNT.
- HOLD_TIMEOUT, 1024, maximum number of clk cycles one master may hold the bus (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  synchronous reset, active-high.
- req  in  INT_MASTER_COUNT  per-master bus request; held high for the whole transaction.
- req_slave  in  INT_MASTER_COUNT*SLAVE_ID_WIDTH  packed target slave ID per master; master i occupies bits [i*SLAVE_ID_WIDTH +: SLAVE_ID_WIDTH].
- done  in  INT_MASTER_COUNT  one-cycle pulse from the owning master at the end of its transaction.
- grant  out  INT_MASTER_COUNT  one-hot (or all-zero) registered bus grant.
- grant_slave  out  SLAVE_ID_WIDTH  slave ID of the current owner; 0 when no owner.
- bus_busy  out  1  high while any grant bit is high.
- timeout  out  1  one-cycle pulse when the watchdog forces a release.
- last_owner  out  $clog2(INT_MASTER_COUNT)  index of the most recently granted master.

Behaviour:
- Reset (rst high at a clk edge):
  - grant=0, grant_slave=0, bus_busy=0, timeout=0, last_owner=INT_MASTER_COUNT-1, so master 0 wins first.
  - State=IDLE, hold counter=0, mask=0.
  - Reset mid-transaction drops the grant on the same edge; no dead cycle is inserted.
- Eligibility: master i is eligible when req[i]=1, its req_slave is not 0 and not greater than INT_SLAVE_COUNT, and mask[i]=0. Invalid slave IDs are ignored silently and never granted.
- State machine IDLE -> HOLD -> GAP -> IDLE.
- IDLE:
  - If any master is eligible, choose the first eligible index scanning (last_owner+1) mod N upward with wrap.
  - On the next edge: grant[winner]=1, grant_slave latched from req_slave[winner], last_owner=winner, counter=0, state=HOLD.
  - Latency is exactly 1 cycle from a sampled req to grant.
- HOLD:
  - grant and grant_slave stay stable; changes to req_slave during HOLD are ignored.
  - Release occurs when done[owner]=1, or req[owner]=0, or (with timeout) counter==HOLD_TIMEOUT-1.
  - On release: next edge grant=0, grant_slave=0, state=GAP.
  - done from a non-owner is ignored.
  - done and a timeout in the same cycle count as a normal release; timeout stays 0.
- GAP:
  - Exactly one cycle with grant=0 so the interconnect can drain.
  - Then IDLE; arbitration happens in IDLE, so the minimum spacing between two grants is 2 idle cycles.
  - Requests arriving during GAP are honoured in IDLE.
- Round-robin: after master k releases, a simultaneous request from k and j≠k goes to j. A single requester can be re-granted back-to-back, subject to the gap.
- Counter: saturating, width $clog2(HOLD_TIMEOUT)+1. Increments every HOLD cycle and clears on entering HOLD.
- bus_busy is a registered copy of |grant and changes on the same edge as grant.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In HOLD, counter==HOLD_TIMEOUT-1 forces a release; timeout pulses high on the same edge grant drops.
  - mask[owner] is set. mask[i] clears when req[i] is sampled 0, so the offender must deassert before it can re-arbitrate.
- ARB_TIMEOUT_EN undefined:
  - No counter and no mask logic; timeout is tied 0.
  - Ownership ends only on done or req deassertion.

Test Plan:
- Reset then req=2'b01, req_slave[0]=2 -> grant=01 and grant_slave=2 one cycle later; done pulse -> grant=00 next edge, one GAP cycle, bus_busy follows grant.
- req=2'b11 from reset with slaves {1,3} -> master0 granted first; after its done, master1 granted (grant=10, grant_slave=3) 2 cycles after release; when master1 is done with both still requesting -> master0 granted next.
- req[0]=1 with req_slave[0]=0 -> never granted, grant stays 00; changing req_slave[0] to 1 -> grant=01 next cycle.
- Owner changes req_slave from 1 to 2 during HOLD -> grant_slave stays 1; owner drops req without done -> release, same timing as done.
- rst asserted in HOLD -> grant=00, last_owner=1 on that edge; first grant after reset goes to master0.
- ARB_TIMEOUT_EN, HOLD_TIMEOUT=8, master0 holds req without done -> grant drops after 8 HOLD cycles with timeout=1 for one cycle; master0 is not re-granted until req[0] drops, and master1 requesting meanwhile is granted.
